// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the PPU max-pooling datapath.
//   - default geometry (lanes, lane width, largest window)
//   - qint8_t: signed two's-complement lane value
//   - lane pack/unpack helpers for the default bus geometry
package ppu_pkg;

  localparam int LANES_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int WIN_MAX_DEF = 4;
  localparam int BUS_W_DEF   = LANES_DEF * DATA_W_DEF;

  typedef logic signed [DATA_W_DEF-1:0] qint8_t;

  // Lane idx lives at bits [idx*DATA_W +: DATA_W] of the packed bus.
  function automatic qint8_t lane_unpack(input logic [BUS_W_DEF-1:0] bus,
                                         input int idx);
    return qint8_t'(bus[idx*DATA_W_DEF +: DATA_W_DEF]);
  endfunction

  function automatic logic [BUS_W_DEF-1:0] lane_pack(input qint8_t lanes [LANES_DEF]);
    logic [BUS_W_DEF-1:0] bus;
    bus = '0;
    for (int i = 0; i < LANES_DEF; i++) begin
      bus[i*DATA_W_DEF +: DATA_W_DEF] = lanes[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/ppu_pool_lane.sv
// ppu_pool_lane: one max-pooling lane.
//   Holds the running maximum of the current window and produces the
//   maximum including the beat currently presented.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   load      first beat of a window: accumulator restarts from din
//   upd       beat accepted this cycle (accumulator advances)
//   din       signed lane input
//   res       max including din (ReLU-clamped when PPU_POOL_RELU_EN is defined)
// Config macro: PPU_POOL_RELU_EN
module ppu_pool_lane #(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     upd,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] res
);

  logic signed [DATA_W-1:0] acc_p0;
  logic signed [DATA_W-1:0] max_v;

  function automatic logic signed [DATA_W-1:0] sat_relu(input logic signed [DATA_W-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction

  // On a tie the accumulator keeps its own value.
  always_comb begin
    max_v = acc_p0;
    if (load)             max_v = din;
    else if (din > acc_p0) max_v = din;
  end

  // stage p0: running maximum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     acc_p0 <= '0;
    else if (upd) acc_p0 <= max_v;
  end

`ifdef PPU_POOL_RELU_EN
  assign res = sat_relu(max_v);
`else
  assign res = max_v;
`endif

endmodule

// File: rtl/ppu_maxpool_array.sv
// ppu_maxpool_array: multi-lane signed max-pooling unit with valid/ready
// handshakes on both sides.
//   cfg_en=1: every win_q accepted beats produce one pooled output beat.
//             Accumulation of the next window overlaps a stalled output.
//   cfg_en=0: combinational pass-through, no state updates.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   cfg_en, cfg_win      pool enable, window size (sampled at window start)
//   in_valid/in_ready    input handshake, in_data lane-packed
//   out_valid/out_ready  output handshake, out_data lane-packed
//   busy                 partial window held or output register occupied
// Config macro: PPU_POOL_RELU_EN (fused ReLU on pooled results)
module ppu_maxpool_array
  import ppu_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int WIN_MAX = WIN_MAX_DEF,
  parameter int CNT_W   = $clog2(WIN_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_en,
  input  logic [CNT_W-1:0]        cfg_win,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_MAX_C = CNT_W'(WIN_MAX);

  logic [CNT_W-1:0]        cnt_p0;
  logic [CNT_W-1:0]        win_q_p0;
  logic                    ov_p0;
  logic [LANES*DATA_W-1:0] out_q_p0;

  logic [CNT_W-1:0]        eff_win;
  logic [CNT_W-1:0]        win_cur;
  logic                    last_beat;
  logic                    pool_ready;
  logic                    accept;
  logic                    first;
  logic                    fin;
  logic [LANES*DATA_W-1:0] lane_res;

  always_comb begin
    eff_win = cfg_win;
    if (cfg_win == '0)           eff_win = ONE_C;
    else if (cfg_win > WIN_MAX_C) eff_win = WIN_MAX_C;
  end

  // At a window start the beat on the bus decides the window it opens.
  assign win_cur    = (cnt_p0 == '0) ? eff_win : win_q_p0;
  assign last_beat  = (cnt_p0 == (win_cur - ONE_C));
  assign pool_ready = !(ov_p0 && !out_ready && last_beat);
  assign accept     = cfg_en && in_valid && pool_ready;
  assign first      = accept && (cnt_p0 == '0);
  assign fin        = accept && last_beat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ppu_pool_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (first),
      .upd  (accept),
      .din  (in_data[i*DATA_W +: DATA_W]),
      .res  (lane_res[i*DATA_W +: DATA_W])
    );
  end

  // stage p0: window control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0   <= '0;
      win_q_p0 <= ONE_C;
      ov_p0    <= 1'b0;
    end else if (!cfg_en) begin
      // Leaving pool mode discards the partial window and pending result.
      cnt_p0 <= '0;
      ov_p0  <= 1'b0;
    end else begin
      if (accept) cnt_p0 <= last_beat ? '0 : cnt_p0 + ONE_C;
      if (first)  win_q_p0 <= eff_win;
      // A refill in the same cycle as a consume keeps the register full.
      if (fin)            ov_p0 <= 1'b1;
      else if (out_ready) ov_p0 <= 1'b0;
    end
  end

  // stage p0: output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     out_q_p0 <= '0;
    else if (fin) out_q_p0 <= lane_res;
  end

  assign out_valid = cfg_en ? ov_p0      : in_valid;
  assign out_data  = cfg_en ? out_q_p0   : in_data;
  assign in_ready  = cfg_en ? pool_ready : out_ready;
  assign busy      = (cnt_p0 != '0) || ov_p0;

endmodule

// File: tb/tb_ppu_maxpool_array.sv
// tb_ppu_maxpool_array: directed self-checking bench for ppu_maxpool_array.
// Honours PPU_POOL_RELU_EN in its expected values.
module tb_ppu_maxpool_array;
  import ppu_pkg::*;

  localparam int CNT_W = $clog2(WIN_MAX_DEF + 1);

  logic             clk;
  logic             rst;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_win;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;

  int          n_checks;
  int          n_errors;
  int          stall_cnt;
  logic [31:0] got_q [$];

  ppu_maxpool_array dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (cfg_en),
    .cfg_win   (cfg_win),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Collect every pooled beat the downstream takes.
  always @(negedge clk) begin
    if (rst && cfg_en && out_valid && out_ready) got_q.push_back(out_data);
    if (rst && cfg_en && in_valid && !in_ready)  stall_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rl(input int v);
`ifdef PPU_POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] pk(input int l3, input int l2, input int l1, input int l0);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic logic [31:0] pkr(input int l3, input int l2, input int l1, input int l0);
    return pk(rl(l3), rl(l2), rl(l1), rl(l0));
  endfunction

  // Present a beat and return #1 after the edge that accepted it.
  task automatic drive_beat(input logic [31:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("beat_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    stall_cnt = 0;
    rst       = 1'b0;
    cfg_en    = 1'b1;
    cfg_win   = CNT_W'(4);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_lane0",     32'(lane_unpack(out_data, 0)), 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    rst = 1'b1;
    idle(2);

    // Window of 4, mixed signs
    got_q.delete();
    drive_beat(pk(127, -128, 1, -5));
    drive_beat(pk(0,   -128, 2,  3));
    drive_beat(pk(0,   -128, 3, -1));
    check("w4a_early_valid", {31'b0, out_valid}, 32'd0);
    check("w4a_busy",        {31'b0, busy},      32'd1);
    drive_beat(pk(0,   -128, 4,  2));
    in_valid = 1'b0;
    check("w4a_valid", {31'b0, out_valid}, 32'd1);
    check("w4a_data",  out_data, pkr(127, -128, 4, 3));
    idle(2);
    check("w4a_drained", {31'b0, out_valid}, 32'd0);

    // Window of 4, all-negative lane 0
    drive_beat(pk( 0, -1, 5, -7));
    drive_beat(pk(-1, -3, 5, -2));
    drive_beat(pk( 1, -2, 5, -9));
    drive_beat(pk(-1, -1, 5, -3));
    in_valid = 1'b0;
    check("w4b_valid", {31'b0, out_valid}, 32'd1);
    check("w4b_data",  out_data, pkr(1, -1, 5, -2));
    idle(3);
    check("w4_count", 32'(got_q.size()), 32'd2);

    // Window of 2, continuous stream
    cfg_win   = CNT_W'(2);
    got_q.delete();
    stall_cnt = 0;
    drive_beat(pk(1, 1, 1, 1));
    drive_beat(pk(9, 9, 9, 9));
    check("w2_latency", {31'b0, out_valid}, 32'd1);
    drive_beat(pk(4, 4, 4, 4));
    drive_beat(pk(2, 2, 2, 2));
    idle(3);
    check("w2_stalls", 32'(stall_cnt), 32'd0);
    check("w2_count",  32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("w2_res0", got_q[0], pk(9, 9, 9, 9));
      check("w2_res1", got_q[1], pk(4, 4, 4, 4));
    end

    // Window of 2, downstream stalled
    got_q.delete();
    out_ready = 1'b0;
    drive_beat(pk(10, 10, 10, 10));
    drive_beat(pk(-20, -20, -20, -20));
    drive_beat(pk(-3, -3, -3, -3));
    check("st_first_beat_taken", {31'b0, busy}, 32'd1);
    in_data = pk(-4, -4, -4, -4);
    @(negedge clk);
    check("st_ready_low", {31'b0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("st_ready_hold", {31'b0, in_ready},  32'd0);
    check("st_valid_hold", {31'b0, out_valid}, 32'd1);
    check("st_data_hold",  out_data, pk(10, 10, 10, 10));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("st_refill_valid", {31'b0, out_valid}, 32'd1);
    idle(3);
    check("st_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("st_res0", got_q[0], pk(10, 10, 10, 10));
      check("st_res1", got_q[1], pkr(-3, -3, -3, -3));
    end

    // cfg_win=0 acts as window 1
    cfg_win = '0;
    got_q.delete();
    drive_beat(pk(5, 5, 5, 5));
    check("w0_valid", {31'b0, out_valid}, 32'd1);
    drive_beat(pk(-6, -6, -6, -6));
    idle(3);
    check("w0_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("w0_res0", got_q[0], pk(5, 5, 5, 5));
      check("w0_res1", got_q[1], pkr(-6, -6, -6, -6));
    end

    // cfg_win=7 clamps to 4
    cfg_win = CNT_W'(7);
    got_q.delete();
    drive_beat(pk(0, 0, 4, 1));
    drive_beat(pk(0, 0, 3, 2));
    drive_beat(pk(0, 0, 2, 3));
    check("w7_no_early", {31'b0, out_valid}, 32'd0);
    drive_beat(pk(0, 0, 1, 4));
    in_valid = 1'b0;
    check("w7_valid", {31'b0, out_valid}, 32'd1);
    check("w7_data",  out_data, pk(0, 0, 4, 4));
    idle(3);
    check("w7_count", 32'(got_q.size()), 32'd1);

    // Bypass: combinational, never clamped
    cfg_en    = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h807F01FF;
    #1;
    check("byp_data",     out_data, 32'h807F01FF);
    check("byp_valid0",   {31'b0, out_valid}, 32'd0);
    check("byp_ready0",   {31'b0, in_ready},  32'd0);
    in_valid = 1'b1;
    #1;
    check("byp_valid1",   {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("byp_ready1",   {31'b0, in_ready},  32'd1);
    in_data = 32'h12345678;
    #1;
    check("byp_data2",    out_data, 32'h12345678);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("byp_no_state", {31'b0, busy}, 32'd0);

    // Reset in the middle of a window
    cfg_en  = 1'b1;
    cfg_win = CNT_W'(4);
    idle(1);
    got_q.delete();
    drive_beat(pk(50, 50, 50, 50));
    drive_beat(pk(60, 60, 60, 60));
    in_valid = 1'b0;
    check("mr_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mr_busy_cleared",  {31'b0, busy},      32'd0);
    check("mr_valid_cleared", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(4);
    check("mr_no_output", 32'(got_q.size()), 32'd0);
    drive_beat(pk(1, 1, 1, 1));
    drive_beat(pk(1, 1, 1, 1));
    check("mr_cnt_restart", {31'b0, out_valid}, 32'd0);
    drive_beat(pk(1, 1, 1, 1));
    drive_beat(pk(9, -9, 9, 9));
    in_valid = 1'b0;
    check("mr_fresh_data", out_data, pk(9, 1, 9, 9));
    idle(3);
    check("mr_fresh_count", 32'(got_q.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ppu_maxpool_array.md
# ppu_maxpool_array

Parametrised multi-lane max-pooling unit for the PPU output path. It reduces a configurable window of consecutive input beats to one output beat per lane using signed Qint8 (two's-complement) comparison. It uses a valid/ready handshake on both sides and overlaps accumulation of the next window with a stalled output. When pooling is disabled it becomes a combinational pass-through.

## Interface
Parameters:
- LANES, 4, number of independent pooling lanes per beat
- DATA_W, 8, lane width in bits, signed two's-complement
- WIN_MAX, 4, largest supported window (beats per output)
- CNT_W, $clog2(WIN_MAX+1), width of window count/config

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- cfg_en  input  1  1 = pool, 0 = bypass
- cfg_win  input  CNT_W  window size in beats, sampled at window start
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_data  output  LANES*DATA_W  pooled result, same lane packing
- busy  output  1  partial window held or output register occupied

## Operation
- Bypass (cfg_en=0) is combinational:
  - out_data = in_data
  - out_valid = in_valid
  - in_ready = out_ready
  - No internal state is updated.
- Pool (cfg_en=1) keeps per-lane accumulators acc[i], a beat counter cnt, a latched window win_q, and an output register with its own valid flag ov.
- First accepted beat of a window (cnt==0):
  - acc[i] loads in_data lane i. It does not compare against a reset value, so all-negative inputs pool correctly.
  - win_q latches the effective window: cfg_win==0 is treated as 1, and cfg_win>WIN_MAX is treated as WIN_MAX.
- Subsequent beats: acc[i] = signed max(acc[i], lane i). On a tie, acc keeps its current value.
- Final beat (cnt==win_q-1):
  - The max including this beat is written to the output register and ov is set.
  - cnt returns to 0.
  - A window of 1 passes each beat through the register.
- in_ready = !(ov && !out_ready && cnt==win_q-1). Only the final beat of a window stalls, and only while the previous result is unconsumed. With cnt==0, win_q means the value the incoming beat would latch.
- ov clears on out_ready unless a new final beat lands in the same cycle. A simultaneous consume and refill keeps ov=1 with the new data.
- busy = (cnt!=0) || ov.
- cfg_en may change only while busy=0. If it drops mid-operation, cnt and ov clear on the next edge, the partial window and the pending output are discarded, and bypass takes effect combinationally.
- cfg_win changes take effect only at the next window start.

## Timing
- Reset values:
  - ov/out_valid = 0
  - out_data register = 0
  - acc = 0
  - cnt = 0
  - win_q = 1
  - busy = 0
  - in_ready = 1 in pool mode; equal to out_ready in bypass
- Latency: out_valid rises on the cycle after the final beat is accepted.
- Throughput: one input beat per cycle sustained while out_ready stays high.
- Reset asserted mid-window clears all state immediately. No output is produced for the interrupted window.

## Configuration
- PPU_POOL_RELU_EN defined: each lane result is clamped to max(result, 0) before the output register, which fuses ReLU. Bypass data is not clamped.
- Undefined: raw signed maximum, negative results preserved.

## Structure
- ppu_pkg holds:
  - default LANES/DATA_W/WIN_MAX as localparams
  - typedef signed logic [DATA_W-1:0] qint8_t
  - the lane-pack/unpack helper function
- Sub-module ppu_pool_lane: one per lane, generated LANES times. Each instance holds the accumulator, signed compare, load-vs-max select, and optional ReLU clamp.
- The top owns cnt, win_q, ov, the handshake, and the bypass mux.

## Test plan
- Reset then idle: out_valid=0, busy=0, in_ready=1 with cfg_en=1.
- win=4, lane0 beats {-5,3,-1,2} -> out lane0 = 3 one cycle after the 4th beat. Beats {-7,-2,-9,-3} -> -2 without the macro, 0 with PPU_POOL_RELU_EN.
- win=2, continuous beats, out_ready=1 -> one output every 2 cycles, no in_ready drop.
- win=2, out_ready=0 after the first result -> the next window's first beat is accepted, the final beat is stalled (in_ready=0) until out_ready=1. Results appear in order, none lost.
- cfg_win=0 -> behaves as window 1. cfg_win=7 with WIN_MAX=4 -> four beats per output.
- cfg_en=0 with in_data=0x80_7F_01_FF -> out_data identical in the same cycle, out_valid follows in_valid. Reset asserted after 2 of 4 beats -> no output, cnt=0.
